// File: rtl/id_regfile_scoreboard_if.sv
// id_regfile_scoreboard_if: WB, read-port, issue and status signals of the ID-stage register file
interface id_regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              WBRegWrite;
    logic [ADDR_W-1:0] WBAddr;
    logic [DATA_W-1:0] WBData;
    logic [ADDR_W-1:0] RsAddr;
    logic [ADDR_W-1:0] RtAddr;
    logic              RsUsed;
    logic              RtUsed;
    logic              IssueValid;
    logic              IssueWrite;
    logic [ADDR_W-1:0] IssueDest;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              Stall;
    logic              ScbErr;
    logic [31:0]       StallCycles;
    modport master (
        output WBRegWrite, WBAddr, WBData, RsAddr, RtAddr, RsUsed, RtUsed,
               IssueValid, IssueWrite, IssueDest,
        input  ReadData1, ReadData2, Stall, ScbErr, StallCycles
    );
    modport slave (
        input  WBRegWrite, WBAddr, WBData, RsAddr, RtAddr, RsUsed, RtUsed,
               IssueValid, IssueWrite, IssueDest,
        output ReadData1, ReadData2, Stall, ScbErr, StallCycles
    );
endinterface

// File: rtl/id_regfile_scoreboard.sv
// id_regfile_scoreboard: MIPS GPR file with WB bypass and pending-write scoreboard; REGFILE_STALL_CNT_EN builds the stall-cycle counter
module id_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input logic                    clk,
    input logic                    reset,
    id_regfile_scoreboard_if.slave bus
);
    localparam int N = 2 ** ADDR_W;
    logic [DATA_W-1:0] rf_q   [N];
    logic [CNT_W-1:0]  pend_q [N];
    logic [CNT_W-1:0]  pend_d [N];
    logic              err_q, err_d;
    logic              wb, ret_rs, ret_rt, ret_dst, byp_rs, byp_rt, haz, full, stall, iss;
    logic [CNT_W-1:0]  eff_rs, eff_rt;
    assign wb      = bus.WBRegWrite && bus.WBAddr != '0 && !reset;
    assign ret_rs  = wb && bus.WBAddr == bus.RsAddr;
    assign ret_rt  = wb && bus.WBAddr == bus.RtAddr;
    assign ret_dst = wb && bus.WBAddr == bus.IssueDest;
    assign byp_rs  = ret_rs;
    assign byp_rt  = ret_rt;
    assign eff_rs  = pend_q[bus.RsAddr] - CNT_W'(ret_rs);
    assign eff_rt  = pend_q[bus.RtAddr] - CNT_W'(ret_rt);
    assign haz     = bus.IssueValid && ((bus.RsUsed && eff_rs != '0) || (bus.RtUsed && eff_rt != '0));
    assign full    = bus.IssueValid && bus.IssueWrite && bus.IssueDest != '0 &&
                     pend_q[bus.IssueDest] == '1 && !ret_dst;
    assign stall   = (haz || full) && !reset;
    assign iss     = bus.IssueValid && bus.IssueWrite && bus.IssueDest != '0 && !stall;
    assign bus.ReadData1 = byp_rs ? bus.WBData : rf_q[bus.RsAddr];
    assign bus.ReadData2 = byp_rt ? bus.WBData : rf_q[bus.RtAddr];
    assign bus.Stall     = stall;
    assign bus.ScbErr    = err_q;
    // Pending counts: issue adds one, retire removes one, retiring an idle register flags an error
    always_comb begin
        for (int r = 0; r < N; r++) begin
            pend_d[r] = pend_q[r];
            if (r != 0) begin
                pend_d[r] = (iss && bus.IssueDest == ADDR_W'(r) && !(wb && bus.WBAddr == ADDR_W'(r))) ?
                                pend_q[r] + CNT_W'(1) :
                            (!(iss && bus.IssueDest == ADDR_W'(r)) && wb && bus.WBAddr == ADDR_W'(r) &&
                             pend_q[r] != '0) ? pend_q[r] - CNT_W'(1) : pend_q[r];
            end
        end
        err_d = err_q || (wb && pend_q[bus.WBAddr] == '0);
    end
    // Register array, scoreboard and error flag; reset drops all in-flight tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                rf_q[r]   <= '0;
                pend_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wb) rf_q[bus.WBAddr] <= bus.WBData;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end
`ifdef REGFILE_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d = (stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    // Saturating count of stalled cycles, cleared only by reset
    always_ff @(posedge clk) begin
        cnt_q <= reset ? 32'd0 : cnt_d;
    end
    assign bus.StallCycles = cnt_q;
`else
    assign bus.StallCycles = 32'd0;
`endif
endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// tb_id_regfile_scoreboard: directed checks of reads, bypass, hazard/full stalls, ScbErr and reset
module tb_id_regfile_scoreboard;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    id_regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    id_regfile_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        bus.WBRegWrite = 0; bus.WBAddr = 0; bus.WBData = 0;
        bus.RsAddr = 0; bus.RtAddr = 0; bus.RsUsed = 0; bus.RtUsed = 0;
        bus.IssueValid = 0; bus.IssueWrite = 0; bus.IssueDest = 0;
    endtask
    task automatic wbw(input logic [4:0] a, input logic [31:0] d);
        bus.WBRegWrite = 1; bus.WBAddr = a; bus.WBData = d;
    endtask
    task automatic issue(input logic [4:0] dst);
        bus.IssueValid = 1; bus.IssueWrite = 1; bus.IssueDest = dst;
    endtask
    task automatic reader(input logic [4:0] rs);
        bus.IssueValid = 1; bus.IssueWrite = 0; bus.RsUsed = 1; bus.RsAddr = rs;
    endtask
    initial begin
        logic [31:0] exp_cnt;
        n_chk = 0;
        n_fail = 0;
        idle();
        reset = 1;
        wbw(5'd4, 32'hDEAD_BEEF);
        reader(5'd4);
        @(negedge clk);
        #1 chk("stall_in_reset", {31'd0, bus.Stall}, 32'd0);
        chk("no_bypass_in_reset", bus.ReadData1, 32'd0);
        @(negedge clk);
        reset = 0;
        idle();
        for (int r = 0; r < 32; r++) begin
            bus.RsAddr = 5'(r);
            bus.RtAddr = 5'(31 - r);
            #1 chk("reset_rd1", bus.ReadData1, 32'd0);
            chk("reset_rd2", bus.ReadData2, 32'd0);
        end
        chk("reset_stall", {31'd0, bus.Stall}, 32'd0);
        chk("reset_scberr", {31'd0, bus.ScbErr}, 32'd0);
        chk("reset_stallcycles", bus.StallCycles, 32'd0);
        @(negedge clk);
        issue(5'd5);
        #1 chk("issue_r5_stall", {31'd0, bus.Stall}, 32'd0);
        @(negedge clk);
        idle();
        wbw(5'd5, 32'h1234_5678);
        bus.RsAddr = 5'd5;
        bus.RtAddr = 5'd5;
        #1 chk("bypass_rd1", bus.ReadData1, 32'h1234_5678);
        chk("bypass_rd2", bus.ReadData2, 32'h1234_5678);
        @(negedge clk);
        idle();
        bus.RsAddr = 5'd5;
        #1 chk("array_rd1", bus.ReadData1, 32'h1234_5678);
        chk("r5_scberr", {31'd0, bus.ScbErr}, 32'd0);
        @(negedge clk);
        idle();
        issue(5'd8);
        #1 chk("issue_r8_stall", {31'd0, bus.Stall}, 32'd0);
        @(negedge clk);
        idle();
        reader(5'd8);
        #1 chk("raw_r8_stall", {31'd0, bus.Stall}, 32'd1);
        @(negedge clk);
        #1 chk("raw_r8_hold1", {31'd0, bus.Stall}, 32'd1);
        @(negedge clk);
        #1 chk("raw_r8_hold2", {31'd0, bus.Stall}, 32'd1);
        wbw(5'd8, 32'd7);
        #1 chk("raw_r8_release", {31'd0, bus.Stall}, 32'd0);
        chk("raw_r8_bypass", bus.ReadData1, 32'd7);
        @(negedge clk);
        idle();
        reader(5'd8);
        #1 chk("r8_pend_clear", {31'd0, bus.Stall}, 32'd0);
        chk("r8_array", bus.ReadData1, 32'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            issue(5'd9);
            #1 chk("r9_issue", {31'd0, bus.Stall}, 32'd0);
        end
        @(negedge clk);
        #1 chk("r9_full", {31'd0, bus.Stall}, 32'd1);
        wbw(5'd9, 32'h0000_0099);
        #1 chk("r9_full_with_wb", {31'd0, bus.Stall}, 32'd0);
        @(negedge clk);
        idle();
        issue(5'd9);
        #1 chk("r9_still_full", {31'd0, bus.Stall}, 32'd1);
        @(negedge clk);
        idle();
        reader(5'd9);
        #1 chk("r9_raw", {31'd0, bus.Stall}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            wbw(5'd9, 32'h900 + 32'(k));
        end
        @(negedge clk);
        idle();
        reader(5'd9);
        #1 chk("r9_drained", {31'd0, bus.Stall}, 32'd0);
        chk("r9_last_value", bus.ReadData1, 32'h902);
        chk("r9_scberr", {31'd0, bus.ScbErr}, 32'd0);
        @(negedge clk);
        idle();
        wbw(5'd3, 32'hCAFE_0003);
        #1 chk("r3_err_not_yet", {31'd0, bus.ScbErr}, 32'd0);
        @(negedge clk);
        idle();
        bus.RtAddr = 5'd3;
        #1 chk("r3_scberr", {31'd0, bus.ScbErr}, 32'd1);
        chk("r3_value", bus.ReadData2, 32'hCAFE_0003);
        @(negedge clk);
        wbw(5'd0, 32'hFFFF_FFFF);
        bus.RsAddr = 5'd0;
        #1 chk("r0_no_bypass", bus.ReadData1, 32'd0);
        @(negedge clk);
        idle();
        #1 chk("r0_reads_zero", bus.ReadData1, 32'd0);
        chk("r0_scberr_sticky", {31'd0, bus.ScbErr}, 32'd1);
        reader(5'd0);
        #1 chk("r0_never_stalls", {31'd0, bus.Stall}, 32'd0);
        reset = 1;
        @(negedge clk);
        reset = 0;
        idle();
        issue(5'd10);
        #1 chk("pre_cnt_zero", bus.StallCycles, 32'd0);
        @(negedge clk);
        idle();
        reader(5'd10);
        #1 chk("cnt_stall", {31'd0, bus.Stall}, 32'd1);
        repeat (10) @(negedge clk);
`ifdef REGFILE_STALL_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        #1 chk("stall_cycles", bus.StallCycles, exp_cnt);
        chk("cnt_stall_held", {31'd0, bus.Stall}, 32'd1);
        reset = 1;
        #1 chk("reset_mid_stall", {31'd0, bus.Stall}, 32'd0);
        @(negedge clk);
        reset = 0;
        #1 chk("post_reset_cnt", bus.StallCycles, 32'd0);
        chk("post_reset_pend", {31'd0, bus.Stall}, 32'd0);
        chk("post_reset_scberr", {31'd0, bus.ScbErr}, 32'd0);
        bus.RtAddr = 5'd5;
        #1 chk("post_reset_r5", bus.ReadData2, 32'd0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
